// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the IF/MEM memory-port arbiter and the pipeline stages
// that drive it.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } mem_size_e;

    // Instruction fetch has no byte enables of its own.
    localparam logic [3:0] INST_WSTRB = 4'hF;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins; on a tie the requester
// that did not win last time is chosen.
module rr_pick2
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  owner_e     last_i,
    output owner_e     grant_o
);

    always_comb begin
        grant_o = OWN_INST;
        case (req_i)
            2'b01:   grant_o = OWN_INST;
            2'b10:   grant_o = OWN_DATA;
            2'b11:   grant_o = (last_i == OWN_INST) ? OWN_DATA : OWN_INST;
            default: grant_o = OWN_INST;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like port between instruction fetch and data access, one
// outstanding transaction at a time, with round-robin tie breaking.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          inst_req,
    input  logic          inst_wr,
    input  logic [1:0]    inst_size,
    input  logic [AW-1:0] inst_addr,
    input  logic [DW-1:0] inst_wdata,
    output logic          inst_addr_ok,
    output logic          inst_data_ok,
    output logic [DW-1:0] inst_rdata,

    input  logic          data_req,
    input  logic          data_wr,
    input  logic [1:0]    data_size,
    input  logic [AW-1:0] data_addr,
    input  logic [DW-1:0] data_wdata,
    input  logic [3:0]    data_wstrb,
    output logic          data_addr_ok,
    output logic          data_data_ok,
    output logic [DW-1:0] data_rdata,

    output logic          mem_req,
    output logic          mem_wr,
    output logic [1:0]    mem_size,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [3:0]    mem_wstrb,
    input  logic          mem_addr_ok,
    input  logic          mem_data_ok,
    input  logic [DW-1:0] mem_rdata
);

    arb_state_e state_q, state_d;
    owner_e     owner_q, owner_d;
    owner_e     last_q,  last_d;
    owner_e     pick;
    logic       any_req;
    logic       addr_hs;
    logic       data_hs;

    assign any_req = inst_req | data_req;

    rr_pick2 u_pick (
        .req_i   ({data_req, inst_req}),
        .last_i  (last_q),
        .grant_o (pick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            owner_q <= OWN_INST;
            last_q  <= OWN_INST;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        case (state_q)
            ARB_IDLE: begin
                if (any_req) begin
                    state_d = ARB_ADDR;
                    owner_d = pick;
                    last_d  = pick;
                end
            end
            ARB_ADDR: begin
                if (mem_addr_ok) begin
                    state_d = ARB_DATA;
                end
            end
            ARB_DATA: begin
                // Re-arbitrate on the completing cycle so a waiting requester
                // is presented on the very next cycle.
                if (mem_data_ok) begin
                    if (any_req) begin
                        state_d = ARB_ADDR;
                        owner_d = pick;
                        last_d  = pick;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign mem_req = (state_q == ARB_ADDR);
    assign addr_hs = (state_q == ARB_ADDR) && mem_addr_ok;
    assign data_hs = (state_q == ARB_DATA) && mem_data_ok;

    always_comb begin
        mem_wr    = inst_wr;
        mem_size  = inst_size;
        mem_addr  = inst_addr;
        mem_wdata = inst_wdata;
        mem_wstrb = INST_WSTRB;
        if (owner_q == OWN_DATA) begin
            mem_wr    = data_wr;
            mem_size  = data_size;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
            mem_wstrb = data_wstrb;
        end
    end

    always_comb begin
        inst_addr_ok = addr_hs && (owner_q == OWN_INST);
        inst_data_ok = data_hs && (owner_q == OWN_INST);
        data_addr_ok = addr_hs && (owner_q == OWN_DATA);
        data_data_ok = data_hs && (owner_q == OWN_DATA);
        inst_rdata   = inst_data_ok ? mem_rdata : '0;
        data_rdata   = data_data_ok ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction-level reference model
// checked every cycle, plus hand-computed expectations per scenario.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32)) u_dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Downstream responder: accepts after cfg_aw wait cycles, answers cfg_dw
    // cycles after acceptance.
    int   cfg_aw = 0, cfg_dw = 0;
    int   a_cnt, d_cnt;
    logic dn_pend;
    assign mem_addr_ok = mem_req && (a_cnt >= cfg_aw);
    assign mem_data_ok = dn_pend && (d_cnt >= cfg_dw);

    always @(posedge clk) begin
        if (rst) begin
            a_cnt <= 0; d_cnt <= 0; dn_pend <= 1'b0;
        end else begin
            if (mem_req && !mem_addr_ok) a_cnt <= a_cnt + 1;
            if (dn_pend && !mem_data_ok) d_cnt <= d_cnt + 1;
            if (mem_data_ok) dn_pend <= 1'b0;
            if (mem_addr_ok) begin
                a_cnt <= 0; d_cnt <= 0; dn_pend <= 1'b1;
            end
        end
    end

    // Reference model: phase 0 = nobody served, 1 = request presented,
    // 2 = awaiting response. who/prev: 0 = inst, 1 = data.
    int   m_phase;
    logic m_who, m_prev;
    logic m_started = 1'b0;
    logic m_log[$];
    logic dut_log[$];

    function automatic logic choose();
        if (inst_req && data_req) return ~m_prev;
        return data_req;
    endfunction

    always @(posedge clk) begin
        m_started <= 1'b1;
        if (rst) begin
            m_phase <= 0; m_who <= 1'b0; m_prev <= 1'b0;
        end else if ((m_phase == 0 || (m_phase == 2 && mem_data_ok)) && (inst_req || data_req)) begin
            m_phase <= 1; m_who <= choose(); m_prev <= choose();
            m_log.push_back(choose());
        end else if (m_phase == 1 && mem_addr_ok) begin
            m_phase <= 2;
        end else if (m_phase == 2 && mem_data_ok) begin
            m_phase <= 0;
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            logic ea, ed;
            ea = (m_phase == 1) && mem_addr_ok;
            ed = (m_phase == 2) && mem_data_ok;
            check("mem_req",      mem_req,      m_phase == 1);
            check("inst_addr_ok", inst_addr_ok, ea && !m_who);
            check("data_addr_ok", data_addr_ok, ea &&  m_who);
            check("inst_data_ok", inst_data_ok, ed && !m_who);
            check("data_data_ok", data_data_ok, ed &&  m_who);
            check("inst_rdata",   inst_rdata,   (ed && !m_who) ? mem_rdata : 32'h0);
            check("data_rdata",   data_rdata,   (ed &&  m_who) ? mem_rdata : 32'h0);
            check("mem_wr",    mem_wr,    m_who ? data_wr    : inst_wr);
            check("mem_size",  mem_size,  m_who ? data_size  : inst_size);
            check("mem_addr",  mem_addr,  m_who ? data_addr  : inst_addr);
            check("mem_wdata", mem_wdata, m_who ? data_wdata : inst_wdata);
            check("mem_wstrb", mem_wstrb, m_who ? data_wstrb : 4'hF);
            if (data_addr_ok) dut_log.push_back(1'b1);
            if (inst_addr_ok) dut_log.push_back(1'b0);
            if (!rst) assert (!(mem_data_ok && mem_req)) else $error("downstream response during address phase");
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int rq, aok, dok, other, unstable;
        rst = 1'b1;
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = '0; inst_wdata = '0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = '0; data_wdata = '0; data_wstrb = '0;
        mem_rdata = '0;
        do_reset();
        check("rst_mem_req", mem_req, 0);
        check("rst_handshakes", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 0);

        // 1: single inst read, zero wait
        inst_req = 1; inst_addr = 32'hBFC00000; mem_rdata = 32'h3C1D0001;
        tick();
        check("t1_mem_req", mem_req, 1);
        check("t1_mem_addr", mem_addr, 32'hBFC00000);
        check("t1_mem_wr", mem_wr, 0);
        check("t1_inst_addr_ok", inst_addr_ok, 1);
        check("t1_data_hs", {data_addr_ok, data_data_ok}, 0);
        tick();
        inst_req = 0;
        check("t1_inst_data_ok", inst_data_ok, 1);
        check("t1_inst_rdata", inst_rdata, 32'h3C1D0001);
        check("t1_data_hs2", {data_addr_ok, data_data_ok}, 0);
        tick();
        check("t1_idle", mem_req, 0);

        // 2: simultaneous requests after reset, data write wins the tie
        do_reset();
        inst_req = 1; inst_addr = 32'h2000;
        data_req = 1; data_wr = 1; data_addr = 32'h1000; data_wdata = 32'hDEADBEEF; data_wstrb = 4'hF;
        tick();
        check("t2_data_addr_ok", data_addr_ok, 1);
        check("t2_inst_addr_ok_lo", inst_addr_ok, 0);
        check("t2_mem_wr", mem_wr, 1);
        check("t2_mem_addr", mem_addr, 32'h1000);
        check("t2_mem_wdata", mem_wdata, 32'hDEADBEEF);
        tick();
        data_req = 0; data_wr = 0;
        check("t2_data_data_ok", data_data_ok, 1);
        tick();
        check("t2_inst_mem_req", mem_req, 1);
        check("t2_inst_addr_ok", inst_addr_ok, 1);
        check("t2_inst_mem_addr", mem_addr, 32'h2000);
        tick();
        inst_req = 0;
        check("t2_inst_data_ok", inst_data_ok, 1);
        tick();

        // 3: both held for 8 transactions; last winner was inst
        dut_log.delete();
        m_log.delete();
        inst_req = 1; inst_addr = 32'h3100;
        data_req = 1; data_addr = 32'h3000; data_wstrb = 4'h3;
        for (int i = 0; i < 16; i++) tick();
        inst_req = 0; data_req = 0;
        tick();
        tick();
        check("t3_dut_grants", dut_log.size(), 8);
        check("t3_model_grants", m_log.size(), 8);
        for (int i = 0; i < 8 && i < dut_log.size(); i++) check("t3_dut_order", dut_log[i], (i % 2) == 0);
        for (int i = 0; i < 8 && i < m_log.size(); i++) check("t3_model_order", m_log[i], (i % 2) == 0);

        // 4: address stall of 3 cycles, response delay of 2
        cfg_aw = 3; cfg_dw = 2;
        inst_req = 1; inst_addr = 32'h4000; mem_rdata = 32'h0BADF00D;
        rq = 0; aok = 0; dok = 0; other = 0; unstable = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 5) inst_req = 0;
            rq += int'(mem_req);
            aok += int'(inst_addr_ok);
            dok += int'(inst_data_ok);
            other += int'(data_addr_ok | data_data_ok);
            if (mem_req && (mem_addr !== 32'h4000 || mem_wr !== 1'b0)) unstable++;
        end
        check("t4_mem_req_cycles", rq, 4);
        check("t4_addr_ok_pulses", aok, 1);
        check("t4_data_ok_pulses", dok, 1);
        check("t4_other_hs", other, 0);
        check("t4_fields_stable", unstable, 0);

        // 5: reset during the data phase, then restart
        cfg_aw = 0; cfg_dw = 3;
        inst_req = 1; inst_addr = 32'h5000;
        tick();
        check("t5_addr_ok", inst_addr_ok, 1);
        tick();
        inst_req = 0; rst = 1;
        check("t5_in_data", mem_req, 0);
        tick();
        check("t5_rst_state", u_dut.state_q, 0);
        check("t5_rst_mem_req", mem_req, 0);
        check("t5_rst_hs", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 0);
        rst = 0; inst_req = 1; cfg_dw = 0; mem_rdata = 32'h55AA55AA;
        tick();
        check("t5_restart_req", mem_req, 1);
        check("t5_restart_addr_ok", inst_addr_ok, 1);
        tick();
        inst_req = 0;
        check("t5_restart_data_ok", inst_data_ok, 1);
        check("t5_restart_rdata", inst_rdata, 32'h55AA55AA);
        tick();

        // 6: byte read by the data requester
        data_req = 1; data_wr = 0; data_size = 2'd0; data_addr = 32'h1003; mem_rdata = 32'h11223344;
        tick();
        check("t6_mem_size", mem_size, 0);
        check("t6_mem_addr", mem_addr, 32'h1003);
        check("t6_data_addr_ok", data_addr_ok, 1);
        tick();
        data_req = 0;
        check("t6_data_data_ok", data_data_ok, 1);
        check("t6_data_rdata", data_rdata, 32'h11223344);
        check("t6_inst_hs", {inst_addr_ok, inst_data_ok}, 0);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
